eh2_dccm_arb: RTL and testbench
===============================

EH2_DCCM_ARB -- requirements
Module: eh2_dccm_arb

Interface
REQ-001: Parameter DCCM_BITS, default 16, is the DCCM address width.
REQ-002: Parameter DCCM_FDATA_WIDTH, default 39, is the data width including ECC.
REQ-003: Parameter DMA_STARVE_MAX, default 15, is the DMA starvation threshold in cycles, legal range 1..255.
REQ-004: clk  input  1  is the single clock; all state is on its rising edge.
REQ-005: rst_l  input  1  is the asynchronous, active-low reset.
REQ-006: lsu_req  input  2  is the per-thread LSU access request; bit t belongs to thread t.
REQ-007: lsu_wr  input  2  is the per-thread write qualifier: 1 means write, 0 means read.
REQ-008: lsu_addr  input  2xDCCM_BITS  is the per-thread address.
REQ-009: lsu_wdata  input  2xDCCM_FDATA_WIDTH  is the per-thread write data.
REQ-010: lsu_gnt  output  2  is the per-thread grant, one-hot or zero.
REQ-011: dma_req, dma_wr  input  1 each  are the DMA request and write qualifier.
REQ-012: dma_addr  input  DCCM_BITS  is the DMA address.
REQ-013: dma_wdata  input  DCCM_FDATA_WIDTH  is the DMA write data.
REQ-014: dma_gnt  output  1  is the DMA grant.
REQ-015: dccm_wren, dccm_rden  output  1 each  are the DCCM port enables.
REQ-016: dccm_addr  output  DCCM_BITS  is the DCCM port address.
REQ-017: dccm_wr_data  output  DCCM_FDATA_WIDTH  is the DCCM port write data.
REQ-018: dccm_rd_data  input  DCCM_FDATA_WIDTH  is DCCM read data, valid one cycle after dccm_rden.
REQ-019: rd_valid  output  1  flags returned read data.
REQ-020: rd_tag  output  2  identifies the read owner: 0 = thread0, 1 = thread1, 2 = DMA.
REQ-021: rd_data  output  DCCM_FDATA_WIDTH  is the returned read data.
REQ-022: dma_starve  output  1  is high while the starvation counter equals DMA_STARVE_MAX.

Function
REQ-023: At most one of lsu_gnt[0], lsu_gnt[1] and dma_gnt shall be high in any cycle; a grant shall be high only when its requester's req is high in the same cycle.
REQ-024: Grants shall be combinational from the current req inputs and registered state, so a request is granted with zero-cycle latency.
REQ-025: When dma_starve is 0, priority is LSU over DMA. When dma_starve is 1 and dma_req is 1, DMA wins that cycle.
REQ-026: LSU threads arbitrate round-robin via a 1-bit rr_ptr naming the preferred thread. After an LSU grant to thread t, rr_ptr becomes ~t. With no LSU grant, rr_ptr holds.
REQ-027: When only one thread requests, it is granted regardless of rr_ptr.
REQ-028: Starvation counter, 8-bit:
- increments by 1 each cycle dma_req=1 and dma_gnt=0, saturating at DMA_STARVE_MAX;
- clears to 0 on dma_gnt=1 or on dma_req=0.
REQ-029: For the granted requester:
- dccm_rden = ~wr and dccm_wren = wr;
- dccm_addr and dccm_wr_data are muxed from that requester.
REQ-030: With no grant: dccm_rden = 0 and dccm_wren = 0; dccm_addr and dccm_wr_data are 0.
REQ-031: A granted read shall produce rd_valid=1 exactly one cycle later, with rd_tag equal to the owner registered at grant and rd_data = dccm_rd_data.
REQ-032: rd_valid shall be 0 in the cycle after a write grant or an idle cycle.
REQ-033: Back-to-back reads shall each return in order with a 1-cycle latency and no bubble.
REQ-034: A requester that drops req in the grant cycle is simply not granted; no request state is held internally.

Reset
REQ-035: While rst_l=0, the following shall be forced asynchronously and hold until the first clk edge after deassertion:
- rr_ptr = 0;
- starvation counter = 0;
- rd_valid = 0, rd_tag = 0;
- dma_starve = 0;
- all grants and DCCM enables = 0.
REQ-036: A read granted in the cycle reset asserts shall not return rd_valid after reset.

Verification
REQ-037: lsu_req=2'b11 reads for 4 cycles, rr_ptr=0 -> lsu_gnt sequence 01,10,01,10; rd_tag 0,1,0,1 each one cycle later.
REQ-038: lsu_req[0]=1 continuous, dma_req=1, DMA_STARVE_MAX=15 -> dma_gnt=0 for 15 cycles, dma_starve=1 in cycle 16, dma_gnt=1 in cycle 16, then counter returns to 0.
REQ-039: DMA write alone (dma_req=1, dma_wr=1, addr 0x1234) -> dccm_wren=1, dccm_addr=0x1234, same cycle; rd_valid=0 next cycle.
REQ-040: Thread1 read addr 0x0040 followed by DMA read addr 0x0080 -> rd_valid two consecutive cycles, rd_tag 1 then 2, rd_data tracking dccm_rd_data.
REQ-041: rst_l asserted mid-stream with counter=7 and a read outstanding -> all outputs 0 immediately; after release, counter=0, no stray rd_valid.
REQ-042: dma_req toggling 1,0,1 while LSU is busy -> counter 1, 0, 1; no DMA grant.

Source files
------------

// File: rtl/eh2_dccm_arb_if.sv
// Bus bundle between the DCCM arbiter and its requesters (two LSU threads, DMA)
// and the single DCCM port, including the registered read-return path.
interface eh2_dccm_arb_if #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39
);
  logic [1:0]                        lsu_req;
  logic [1:0]                        lsu_wr;
  logic [1:0][DCCM_BITS-1:0]         lsu_addr;
  logic [1:0][DCCM_FDATA_WIDTH-1:0]  lsu_wdata;
  logic [1:0]                        lsu_gnt;
  logic                              dma_req;
  logic                              dma_wr;
  logic [DCCM_BITS-1:0]              dma_addr;
  logic [DCCM_FDATA_WIDTH-1:0]       dma_wdata;
  logic                              dma_gnt;
  logic                              dccm_wren;
  logic                              dccm_rden;
  logic [DCCM_BITS-1:0]              dccm_addr;
  logic [DCCM_FDATA_WIDTH-1:0]       dccm_wr_data;
  logic [DCCM_FDATA_WIDTH-1:0]       dccm_rd_data;
  logic                              rd_valid;
  logic [1:0]                        rd_tag;
  logic [DCCM_FDATA_WIDTH-1:0]       rd_data;
  logic                              dma_starve;

  modport master (
    output lsu_req, lsu_wr, lsu_addr, lsu_wdata, dma_req, dma_wr, dma_addr, dma_wdata,
           dccm_rd_data,
    input  lsu_gnt, dma_gnt, dccm_wren, dccm_rden, dccm_addr, dccm_wr_data,
           rd_valid, rd_tag, rd_data, dma_starve
  );

  modport slave (
    input  lsu_req, lsu_wr, lsu_addr, lsu_wdata, dma_req, dma_wr, dma_addr, dma_wdata,
           dccm_rd_data,
    output lsu_gnt, dma_gnt, dccm_wren, dccm_rden, dccm_addr, dccm_wr_data,
           rd_valid, rd_tag, rd_data, dma_starve
  );
endinterface

// File: rtl/eh2_dccm_arb.sv
// Single-port DCCM arbiter: round-robin between two LSU threads, LSU over DMA
// unless DMA has waited DMA_STARVE_MAX cycles; zero-latency grants, 1-cycle reads.
module eh2_dccm_arb #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int DMA_STARVE_MAX   = 15
) (
  input logic           clk,
  input logic           rst_l,
  eh2_dccm_arb_if.slave bus
);
  localparam logic [7:0] STARVE_MAX = 8'(DMA_STARVE_MAX);

  logic [7:0] starve_cnt_reg, starve_cnt_next;
  logic       rr_ptr_reg, rr_ptr_next;
  logic       rd_pend_reg;
  logic [1:0] rd_tag_reg, rd_tag_next;

  logic       starve;
  logic [1:0] lsu_gnt;
  logic       dma_gnt;
  logic       any_gnt;
  logic       wr_sel;

  logic [1:0][DCCM_BITS-1:0]        lsu_addr_m;
  logic [1:0][DCCM_FDATA_WIDTH-1:0] lsu_wdata_m;

  assign starve = (starve_cnt_reg == STARVE_MAX);

  // Grants are gated by rst_l so they drop asynchronously with reset.
  always_comb begin
    lsu_gnt = 2'b00;
    dma_gnt = 1'b0;
    if (rst_l) begin
      if (bus.dma_req && (starve || (bus.lsu_req == 2'b00))) begin
        dma_gnt = 1'b1;
      end else if (bus.lsu_req == 2'b11) begin
        lsu_gnt = rr_ptr_reg ? 2'b10 : 2'b01;
      end else begin
        lsu_gnt = bus.lsu_req;
      end
    end
  end

  // AND-OR mux: each thread contributes only when granted, grants are one-hot.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lsu_mux
      assign lsu_addr_m[gi]  = {DCCM_BITS{lsu_gnt[gi]}} & bus.lsu_addr[gi];
      assign lsu_wdata_m[gi] = {DCCM_FDATA_WIDTH{lsu_gnt[gi]}} & bus.lsu_wdata[gi];
    end
  endgenerate

  assign any_gnt = (|lsu_gnt) | dma_gnt;
  assign wr_sel  = (|(lsu_gnt & bus.lsu_wr)) | (dma_gnt & bus.dma_wr);

  assign bus.lsu_gnt      = lsu_gnt;
  assign bus.dma_gnt      = dma_gnt;
  assign bus.dccm_wren    = wr_sel;
  assign bus.dccm_rden    = any_gnt & ~wr_sel;
  assign bus.dccm_addr    = lsu_addr_m[0] | lsu_addr_m[1] | ({DCCM_BITS{dma_gnt}} & bus.dma_addr);
  assign bus.dccm_wr_data = lsu_wdata_m[0] | lsu_wdata_m[1] |
                            ({DCCM_FDATA_WIDTH{dma_gnt}} & bus.dma_wdata);

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (lsu_gnt[0]) begin
      rr_ptr_next = 1'b1;
    end else if (lsu_gnt[1]) begin
      rr_ptr_next = 1'b0;
    end

    starve_cnt_next = starve_cnt_reg;
    if (!bus.dma_req || dma_gnt) begin
      starve_cnt_next = 8'd0;
    end else if (starve_cnt_reg != STARVE_MAX) begin
      starve_cnt_next = starve_cnt_reg + 8'd1;
    end

    rd_tag_next = rd_tag_reg;
    if (bus.dccm_rden) begin
      rd_tag_next = dma_gnt ? 2'd2 : (lsu_gnt[1] ? 2'd1 : 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_ptr_reg     <= 1'b0;
      starve_cnt_reg <= 8'd0;
      rd_pend_reg    <= 1'b0;
      rd_tag_reg     <= 2'd0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      starve_cnt_reg <= starve_cnt_next;
      rd_pend_reg    <= bus.dccm_rden;
      rd_tag_reg     <= rd_tag_next;
    end
  end

  assign bus.rd_valid   = rd_pend_reg;
  assign bus.rd_tag     = rd_tag_reg;
  assign bus.rd_data    = rd_pend_reg ? bus.dccm_rd_data : '0;
  assign bus.dma_starve = starve;
endmodule

// File: tb/tb_eh2_dccm_arb.sv
// Directed self-checking bench for eh2_dccm_arb: round-robin, starvation,
// DMA write, read return ordering and asynchronous reset.
module tb_eh2_dccm_arb;
  logic clk;
  logic rst_l;
  int   err_cnt;
  int   chk_cnt;

  eh2_dccm_arb_if #(.DCCM_BITS(16), .DCCM_FDATA_WIDTH(39)) bus ();

  eh2_dccm_arb #(.DCCM_BITS(16), .DCCM_FDATA_WIDTH(39), .DMA_STARVE_MAX(15)) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.lsu_req      = 2'b00;
    bus.lsu_wr       = 2'b00;
    bus.lsu_addr     = '0;
    bus.lsu_wdata    = '0;
    bus.dma_req      = 1'b0;
    bus.dma_wr       = 1'b0;
    bus.dma_addr     = '0;
    bus.dma_wdata    = '0;
    bus.dccm_rd_data = '0;
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    clr();
    rst_l = 1'b0;
    bus.lsu_req = 2'b11;
    bus.dma_req = 1'b1;
    #3;
    chk("rst_lsu_gnt", 64'(bus.lsu_gnt), 0);
    chk("rst_dma_gnt", 64'(bus.dma_gnt), 0);
    chk("rst_rden", 64'(bus.dccm_rden), 0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 0);
    chk("rst_rd_tag", 64'(bus.rd_tag), 0);
    chk("rst_starve", 64'(bus.dma_starve), 0);
    tick();
    tick();
    rst_l = 1'b1;
    clr();
    tick();

    // Round-robin on both threads reading
    bus.lsu_req = 2'b11;
    bus.lsu_addr[0] = 16'h0010;
    bus.lsu_addr[1] = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      bus.dccm_rd_data = 39'(64'h100 + 64'(i));
      @(negedge clk);
      chk("rr_gnt", 64'(bus.lsu_gnt), (i % 2) ? 64'd2 : 64'd1);
      chk("rr_addr", 64'(bus.dccm_addr), (i % 2) ? 64'h20 : 64'h10);
      chk("rr_rden", 64'(bus.dccm_rden), 1);
      if (i > 0) begin
        chk("rr_vld", 64'(bus.rd_valid), 1);
        chk("rr_tag", 64'(bus.rd_tag), 64'((i - 1) % 2));
        chk("rr_data", 64'(bus.rd_data), 64'h100 + 64'(i));
      end else begin
        chk("rr_vld0", 64'(bus.rd_valid), 0);
      end
      tick();
    end
    clr();
    bus.dccm_rd_data = 39'h1AB;
    @(negedge clk);
    chk("rr_last_vld", 64'(bus.rd_valid), 1);
    chk("rr_last_tag", 64'(bus.rd_tag), 1);
    chk("rr_last_data", 64'(bus.rd_data), 64'h1AB);
    chk("idle_rden", 64'(bus.dccm_rden), 0);
    chk("idle_addr", 64'(bus.dccm_addr), 0);
    tick();
    @(negedge clk);
    chk("idle_vld", 64'(bus.rd_valid), 0);
    tick();

    // Single requesters ignore rr_ptr; rr_ptr follows the last grant
    bus.lsu_req = 2'b10;
    bus.lsu_addr[1] = 16'h0200;
    @(negedge clk);
    chk("single_t1_gnt", 64'(bus.lsu_gnt), 2);
    tick();
    clr();
    bus.lsu_req = 2'b01;
    bus.lsu_wr  = 2'b01;
    bus.lsu_addr[0]  = 16'h0300;
    bus.lsu_wdata[0] = 39'h55AA;
    @(negedge clk);
    chk("t0_wr_gnt", 64'(bus.lsu_gnt), 1);
    chk("t0_wren", 64'(bus.dccm_wren), 1);
    chk("t0_rden", 64'(bus.dccm_rden), 0);
    chk("t0_addr", 64'(bus.dccm_addr), 64'h300);
    chk("t0_wdata", 64'(bus.dccm_wr_data), 64'h55AA);
    tick();
    clr();
    bus.lsu_req = 2'b11;
    @(negedge clk);
    chk("rr_after_t0", 64'(bus.lsu_gnt), 2);
    chk("vld_after_wr", 64'(bus.rd_valid), 0);
    tick();

    // DMA write alone
    clr();
    bus.dma_req   = 1'b1;
    bus.dma_wr    = 1'b1;
    bus.dma_addr  = 16'h1234;
    bus.dma_wdata = 39'h5A_DEAD_BEEF;
    @(negedge clk);
    chk("dmaw_gnt", 64'(bus.dma_gnt), 1);
    chk("dmaw_wren", 64'(bus.dccm_wren), 1);
    chk("dmaw_rden", 64'(bus.dccm_rden), 0);
    chk("dmaw_addr", 64'(bus.dccm_addr), 64'h1234);
    chk("dmaw_wdata", 64'(bus.dccm_wr_data), 64'h5A_DEAD_BEEF);
    tick();
    clr();
    @(negedge clk);
    chk("dmaw_next_vld", 64'(bus.rd_valid), 0);
    chk("dmaw_next_wren", 64'(bus.dccm_wren), 0);
    tick();

    // Starvation: LSU thread0 hogs the port while DMA waits
    bus.lsu_req = 2'b01;
    bus.lsu_addr[0] = 16'h0010;
    bus.dma_req = 1'b1;
    bus.dma_addr = 16'h0BEE;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk("stv_dma_gnt", 64'(bus.dma_gnt), 0);
      chk("stv_starve", 64'(bus.dma_starve), 0);
      chk("stv_lsu_gnt", 64'(bus.lsu_gnt), 1);
      tick();
    end
    @(negedge clk);
    chk("stv16_starve", 64'(bus.dma_starve), 1);
    chk("stv16_dma_gnt", 64'(bus.dma_gnt), 1);
    chk("stv16_lsu_gnt", 64'(bus.lsu_gnt), 0);
    chk("stv16_addr", 64'(bus.dccm_addr), 64'h0BEE);
    tick();
    bus.dccm_rd_data = 39'h3C;
    @(negedge clk);
    chk("stv17_cnt", 64'(dut.starve_cnt_reg), 0);
    chk("stv17_starve", 64'(bus.dma_starve), 0);
    chk("stv17_lsu_gnt", 64'(bus.lsu_gnt), 1);
    chk("stv17_vld", 64'(bus.rd_valid), 1);
    chk("stv17_tag", 64'(bus.rd_tag), 2);
    chk("stv17_data", 64'(bus.rd_data), 64'h3C);
    tick();
    clr();
    tick();
    tick();

    // Thread1 read then DMA read, back to back
    bus.lsu_req = 2'b10;
    bus.lsu_addr[1] = 16'h0040;
    @(negedge clk);
    chk("b2b_t1_gnt", 64'(bus.lsu_gnt), 2);
    chk("b2b_t1_addr", 64'(bus.dccm_addr), 64'h40);
    tick();
    clr();
    bus.dma_req = 1'b1;
    bus.dma_addr = 16'h0080;
    bus.dccm_rd_data = 39'h111;
    @(negedge clk);
    chk("b2b_dma_gnt", 64'(bus.dma_gnt), 1);
    chk("b2b_dma_addr", 64'(bus.dccm_addr), 64'h80);
    chk("b2b_vld1", 64'(bus.rd_valid), 1);
    chk("b2b_tag1", 64'(bus.rd_tag), 1);
    chk("b2b_data1", 64'(bus.rd_data), 64'h111);
    tick();
    clr();
    bus.dccm_rd_data = 39'h222;
    @(negedge clk);
    chk("b2b_vld2", 64'(bus.rd_valid), 1);
    chk("b2b_tag2", 64'(bus.rd_tag), 2);
    chk("b2b_data2", 64'(bus.rd_data), 64'h222);
    tick();
    @(negedge clk);
    chk("b2b_vld3", 64'(bus.rd_valid), 0);
    tick();

    // dma_req toggling under a busy LSU
    bus.lsu_req = 2'b01;
    bus.dma_req = 1'b1;
    @(negedge clk);
    chk("tgl_cnt0", 64'(dut.starve_cnt_reg), 0);
    chk("tgl_gnt0", 64'(bus.dma_gnt), 0);
    tick();
    bus.dma_req = 1'b0;
    @(negedge clk);
    chk("tgl_cnt1", 64'(dut.starve_cnt_reg), 1);
    tick();
    bus.dma_req = 1'b1;
    @(negedge clk);
    chk("tgl_cnt2", 64'(dut.starve_cnt_reg), 0);
    chk("tgl_gnt2", 64'(bus.dma_gnt), 0);
    tick();
    @(negedge clk);
    chk("tgl_cnt3", 64'(dut.starve_cnt_reg), 1);
    chk("tgl_gnt3", 64'(bus.dma_gnt), 0);
    tick();

    // Reset mid-stream with counter at 7 and a read outstanding
    clr();
    tick();
    bus.lsu_req = 2'b01;
    bus.dma_req = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    @(negedge clk);
    chk("mid_cnt7", 64'(dut.starve_cnt_reg), 7);
    chk("mid_vld", 64'(bus.rd_valid), 1);
    chk("mid_gnt", 64'(bus.lsu_gnt), 1);
    #1;
    rst_l = 1'b0;
    #1;
    chk("arst_lsu_gnt", 64'(bus.lsu_gnt), 0);
    chk("arst_dma_gnt", 64'(bus.dma_gnt), 0);
    chk("arst_rden", 64'(bus.dccm_rden), 0);
    chk("arst_wren", 64'(bus.dccm_wren), 0);
    chk("arst_addr", 64'(bus.dccm_addr), 0);
    chk("arst_vld", 64'(bus.rd_valid), 0);
    chk("arst_tag", 64'(bus.rd_tag), 0);
    chk("arst_starve", 64'(bus.dma_starve), 0);
    chk("arst_cnt", 64'(dut.starve_cnt_reg), 0);
    tick();
    rst_l = 1'b1;
    clr();
    @(negedge clk);
    chk("post_rst_vld", 64'(bus.rd_valid), 0);
    chk("post_rst_cnt", 64'(dut.starve_cnt_reg), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
